// File: rtl/dbg_cmd_bridge_sysclk.sv
// -----------------------------------------------------------------------------
// dbg_cmd_bridge_sysclk
//
// System-clock half of the multicore debug slave. The virtual-JTAG update
// strobes are synchronised into clk and edge-detected. Each Update-DR becomes
// one command. The command is routed to a single CPU debug module with a
// per-core valid/ack handshake. Overrun, bad-select and (optionally) ack
// timeout conditions are reported in sticky status flags.
//
// Optional feature macro: DBG_CMD_TIMEOUT_EN
//   When defined, a pending command is abandoned after TIMEOUT_CYCLES cycles
//   without an ack, and err_timeout is set.
//   When undefined, a pending command waits indefinitely and err_timeout is 0.
//
// Ports:
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   ir_in        JTAG IR (quasi-static around the strobes)
//   sr           JTAG scan register (quasi-static after update)
//   vs_udr       virtual Update-DR strobe (tck domain)
//   vs_uir       virtual Update-IR strobe (tck domain)
//   cmd_ack      per-core command acknowledge
//   clr_status   one-cycle pulse that clears the sticky error flags
//   jdo          captured sr of the current/last accepted command
//   cmd_ir       captured ir_in of the current command
//   cmd_action   captured sr[SR_W-1] (1 = take_action)
//   cmd_valid    one-hot pending-command indication per core
//   ir_update    one-cycle pulse per synchronised vs_uir rise
//   busy         a command is pending
//   err_overrun  sticky: Update-DR arrived while a command was pending
//   err_badsel   sticky: select field addressed a non-existent core
//   err_timeout  sticky: a pending command timed out (0 without the macro)
// -----------------------------------------------------------------------------
module dbg_cmd_bridge_sysclk #(
  parameter int SR_W           = 38,
  parameter int IR_W           = 2,
  parameter int NUM_CORES      = 2,
  parameter int SEL_W          = 1,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [IR_W-1:0]      ir_in,
  input  logic [SR_W-1:0]      sr,
  input  logic                 vs_udr,
  input  logic                 vs_uir,
  input  logic [NUM_CORES-1:0] cmd_ack,
  input  logic                 clr_status,
  output logic [SR_W-1:0]      jdo,
  output logic [IR_W-1:0]      cmd_ir,
  output logic                 cmd_action,
  output logic [NUM_CORES-1:0] cmd_valid,
  output logic                 ir_update,
  output logic                 busy,
  output logic                 err_overrun,
  output logic                 err_badsel,
  output logic                 err_timeout
);

  typedef enum logic [0:0] {IDLE = 1'b0, PEND = 1'b1} state_t;

  // ---------------------------------------------------------------------------
  // Strobe synchronisers plus history flop for rising-edge detection.
  // Stage 0 samples the raw strobe; stage SYNC_STAGES-1 is the settled copy.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] udr_sync_reg;
  logic [SYNC_STAGES-1:0] uir_sync_reg;
  logic                   udr_hist_reg;
  logic                   uir_hist_reg;
  logic                   udr_pulse;
  logic                   uir_pulse;
  logic                   ir_update_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      udr_sync_reg  <= '0;
      uir_sync_reg  <= '0;
      udr_hist_reg  <= 1'b0;
      uir_hist_reg  <= 1'b0;
      ir_update_reg <= 1'b0;
    end else begin
      udr_sync_reg  <= {udr_sync_reg[SYNC_STAGES-2:0], vs_udr};
      uir_sync_reg  <= {uir_sync_reg[SYNC_STAGES-2:0], vs_uir};
      udr_hist_reg  <= udr_sync_reg[SYNC_STAGES-1];
      uir_hist_reg  <= uir_sync_reg[SYNC_STAGES-1];
      ir_update_reg <= uir_pulse;
    end
  end

  assign udr_pulse = udr_sync_reg[SYNC_STAGES-1] & ~udr_hist_reg;
  assign uir_pulse = uir_sync_reg[SYNC_STAGES-1] & ~uir_hist_reg;

  // ---------------------------------------------------------------------------
  // Target select decode
  // ---------------------------------------------------------------------------
  logic [SEL_W-1:0]     sel;
  logic                 sel_ok;
  logic [NUM_CORES-1:0] sel_onehot;

  assign sel    = sr[SR_W-2 -: SEL_W];
  assign sel_ok = (32'(sel) < NUM_CORES);

  for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_sel_dec
    assign sel_onehot[gi] = (32'(sel) == gi);
  end

  // ---------------------------------------------------------------------------
  // Command FSM
  // ---------------------------------------------------------------------------
  state_t               state_reg, state_next;
  logic [SR_W-1:0]      jdo_reg, jdo_next;
  logic [IR_W-1:0]      cmd_ir_reg, cmd_ir_next;
  logic                 cmd_action_reg, cmd_action_next;
  logic [NUM_CORES-1:0] cmd_valid_reg, cmd_valid_next;
  logic                 busy_reg, busy_next;
  logic                 overrun_reg, overrun_next;
  logic                 badsel_reg, badsel_next;
  logic                 ack_hit;
  logic                 take_cmd;

  // cmd_valid is one-hot on the target lane, so masking the acks with it
  // ignores acks on every other lane.
  assign ack_hit = |(cmd_ack & cmd_valid_reg);

`ifdef DBG_CMD_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TO_W-1:0] timer_reg, timer_next;
  logic            timeout_reg, timeout_next;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      jdo_reg        <= '0;
      cmd_ir_reg     <= '0;
      cmd_action_reg <= 1'b0;
      cmd_valid_reg  <= '0;
      busy_reg       <= 1'b0;
      overrun_reg    <= 1'b0;
      badsel_reg     <= 1'b0;
`ifdef DBG_CMD_TIMEOUT_EN
      timer_reg      <= '0;
      timeout_reg    <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      jdo_reg        <= jdo_next;
      cmd_ir_reg     <= cmd_ir_next;
      cmd_action_reg <= cmd_action_next;
      cmd_valid_reg  <= cmd_valid_next;
      busy_reg       <= busy_next;
      overrun_reg    <= overrun_next;
      badsel_reg     <= badsel_next;
`ifdef DBG_CMD_TIMEOUT_EN
      timer_reg      <= timer_next;
      timeout_reg    <= timeout_next;
`endif
    end
  end

  always_comb begin
    state_next      = state_reg;
    jdo_next        = jdo_reg;
    cmd_ir_next     = cmd_ir_reg;
    cmd_action_next = cmd_action_reg;
    cmd_valid_next  = cmd_valid_reg;
    busy_next       = busy_reg;
    // Clear first, then set events below, so a set in the clear cycle wins.
    overrun_next    = overrun_reg & ~clr_status;
    badsel_next     = badsel_reg & ~clr_status;
    take_cmd        = 1'b0;
`ifdef DBG_CMD_TIMEOUT_EN
    timeout_next    = timeout_reg & ~clr_status;
    timer_next      = (state_reg == PEND) ? timer_reg + 1'b1 : timer_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (udr_pulse) begin
          take_cmd = 1'b1;
        end
      end
      PEND: begin
        if (ack_hit) begin
          // Handshake complete; a strobe in the same cycle starts the next
          // command with no idle cycle in between.
          state_next     = IDLE;
          cmd_valid_next = '0;
          busy_next      = 1'b0;
          take_cmd       = udr_pulse;
        end else begin
          if (udr_pulse) begin
            overrun_next = 1'b1;
          end
`ifdef DBG_CMD_TIMEOUT_EN
          if (timer_reg == TO_W'(TIMEOUT_CYCLES - 1)) begin
            state_next     = IDLE;
            cmd_valid_next = '0;
            busy_next      = 1'b0;
            timeout_next   = 1'b1;
          end
`endif
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (take_cmd) begin
      if (sel_ok) begin
        state_next      = PEND;
        jdo_next        = sr;
        cmd_ir_next     = ir_in;
        cmd_action_next = sr[SR_W-1];
        cmd_valid_next  = sel_onehot;
        busy_next       = 1'b1;
`ifdef DBG_CMD_TIMEOUT_EN
        timer_next      = '0;
`endif
      end else begin
        badsel_next = 1'b1;
      end
    end
  end

  assign jdo         = jdo_reg;
  assign cmd_ir      = cmd_ir_reg;
  assign cmd_action  = cmd_action_reg;
  assign cmd_valid   = cmd_valid_reg;
  assign ir_update   = ir_update_reg;
  assign busy        = busy_reg;
  assign err_overrun = overrun_reg;
  assign err_badsel  = badsel_reg;
`ifdef DBG_CMD_TIMEOUT_EN
  assign err_timeout = timeout_reg;
`else
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_dbg_cmd_bridge_sysclk.sv
// -----------------------------------------------------------------------------
// tb_dbg_cmd_bridge_sysclk
//
// Directed bench for dbg_cmd_bridge_sysclk, configured with three cores and a
// two-bit select field (sel = sr[36:35], action = sr[37]) so that the
// bad-select case is reachable. TIMEOUT_CYCLES is 8; the timeout step expects
// a drop only when DBG_CMD_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_dbg_cmd_bridge_sysclk;

  localparam int SR_W = 38;
  localparam int IR_W = 2;
  localparam int NC   = 3;

  logic            clk;
  logic            reset_n;
  logic [IR_W-1:0] ir_in;
  logic [SR_W-1:0] sr;
  logic            vs_udr;
  logic            vs_uir;
  logic [NC-1:0]   cmd_ack;
  logic            clr_status;
  logic [SR_W-1:0] jdo;
  logic [IR_W-1:0] cmd_ir;
  logic            cmd_action;
  logic [NC-1:0]   cmd_valid;
  logic            ir_update;
  logic            busy;
  logic            err_overrun;
  logic            err_badsel;
  logic            err_timeout;

  int vectors;
  int miscompares;

  // sel=0 action=0 / sel=1 action=1 / sel=2 / sel=3 (bad) / sel=0 alt
  logic [SR_W-1:0] sr_a;
  logic [SR_W-1:0] sr_b;
  logic [SR_W-1:0] sr_c;
  logic [SR_W-1:0] sr_bad;
  logic [SR_W-1:0] sr_a2;

  dbg_cmd_bridge_sysclk #(
    .SR_W(SR_W), .IR_W(IR_W), .NUM_CORES(NC), .SEL_W(2),
    .SYNC_STAGES(2), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ir_in(ir_in), .sr(sr),
    .vs_udr(vs_udr), .vs_uir(vs_uir), .cmd_ack(cmd_ack),
    .clr_status(clr_status), .jdo(jdo), .cmd_ir(cmd_ir),
    .cmd_action(cmd_action), .cmd_valid(cmd_valid), .ir_update(ir_update),
    .busy(busy), .err_overrun(err_overrun), .err_badsel(err_badsel),
    .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle 1 ns past the edge for driving and sampling.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One-cycle Update-DR pulse; returns after the edge at which the command
  // becomes visible (3rd edge with two sync stages).
  task automatic udr_strobe;
    vs_udr = 1'b1;
    tick;
    vs_udr = 1'b0;
    tick;
    tick;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    sr_a   = {3'b000, 35'h0_0000_00AB} | 38'h1_0000_0000;
    sr_b   = {3'b101, 35'h5_5555_1234};
    sr_c   = {3'b010, 35'h0_0BAD_F00D};
    sr_bad = {3'b011, 35'h1_2345_6789};
    sr_a2  = {3'b000, 35'h0_0000_5A5A};
    reset_n    = 1'b0;
    ir_in      = '0;
    sr         = '0;
    vs_udr     = 1'b0;
    vs_uir     = 1'b0;
    cmd_ack    = '0;
    clr_status = 1'b0;

    // Reset state
    repeat (3) tick;
    check("rst_valid", 64'(cmd_valid), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_jdo", 64'(jdo), 64'h0);
    check("rst_irupd", 64'(ir_update), 64'h0);
    check("rst_errs", 64'({err_overrun, err_badsel, err_timeout}), 64'h0);
    reset_n = 1'b1;
    tick;

    // Basic route to core 0, with latency check
    sr = sr_a; ir_in = 2'b01;
    vs_udr = 1'b1; tick; vs_udr = 1'b0; tick;
    check("lat_valid_e2", 64'(cmd_valid), 64'h0);
    tick;
    check("basic_valid", 64'(cmd_valid), 64'h1);
    check("basic_jdo", 64'(jdo), 64'h1_0000_00AB);
    check("basic_action", 64'(cmd_action), 64'h0);
    check("basic_ir", 64'(cmd_ir), 64'h1);
    check("basic_busy", 64'(busy), 64'h1);
    cmd_ack = 3'b001; tick; cmd_ack = '0;
    check("basic_ack_valid", 64'(cmd_valid), 64'h0);
    check("basic_ack_busy", 64'(busy), 64'h0);

    // Core 1 with action; non-target ack ignored
    sr = sr_b; ir_in = 2'b10;
    udr_strobe;
    check("c1_valid", 64'(cmd_valid), 64'h2);
    check("c1_action", 64'(cmd_action), 64'h1);
    cmd_ack = 3'b001; repeat (3) tick;
    check("c1_wrong_ack", 64'(cmd_valid), 64'h2);
    cmd_ack = 3'b010; tick; cmd_ack = '0;
    check("c1_release", 64'(cmd_valid), 64'h0);

    // Overrun: second strobe while pending and unacked
    sr = sr_a; ir_in = 2'b01;
    udr_strobe;
    sr = sr_c; ir_in = 2'b11;
    udr_strobe;
    check("ovr_flag", 64'(err_overrun), 64'h1);
    check("ovr_jdo", 64'(jdo), 64'(sr_a));
    check("ovr_ir", 64'(cmd_ir), 64'h1);
    check("ovr_valid", 64'(cmd_valid), 64'h1);
    clr_status = 1'b1; tick; clr_status = 1'b0;
    check("ovr_clr", 64'(err_overrun), 64'h0);
    cmd_ack = 3'b001; tick; cmd_ack = '0;
    check("ovr_release", 64'(busy), 64'h0);

    // Ack and new command in the same cycle
    sr = sr_a; ir_in = 2'b01;
    udr_strobe;
    sr = sr_b; ir_in = 2'b10;
    vs_udr = 1'b1; tick; vs_udr = 1'b0; tick;
    check("col_pre_valid", 64'(cmd_valid), 64'h1);
    cmd_ack = 3'b001; tick; cmd_ack = '0;
    check("col_valid", 64'(cmd_valid), 64'h2);
    check("col_busy", 64'(busy), 64'h1);
    check("col_ovr", 64'(err_overrun), 64'h0);
    check("col_jdo", 64'(jdo), 64'(sr_b));
    cmd_ack = 3'b010; tick; cmd_ack = '0;

    // Long strobe: 20 cycles high gives one command only
    sr = sr_a2; ir_in = 2'b00;
    vs_udr = 1'b1;
    repeat (3) tick;
    check("long_valid", 64'(cmd_valid), 64'h1);
    cmd_ack = 3'b001; tick; cmd_ack = '0;
    repeat (16) tick;
    vs_udr = 1'b0;
    check("long_no_recmd", 64'(cmd_valid), 64'h0);
    check("long_busy", 64'(busy), 64'h0);
    check("long_ovr", 64'(err_overrun), 64'h0);
    repeat (3) tick;

    // ir_update: single pulse, jdo untouched
    vs_uir = 1'b1;
    tick; tick;
    check("uir_e2", 64'(ir_update), 64'h0);
    tick;
    check("uir_pulse", 64'(ir_update), 64'h1);
    tick;
    check("uir_end", 64'(ir_update), 64'h0);
    check("uir_jdo", 64'(jdo), 64'(sr_a2));
    repeat (3) tick;
    vs_uir = 1'b0;
    repeat (3) tick;

    // Bad select
    sr = sr_bad;
    udr_strobe;
    check("bad_flag", 64'(err_badsel), 64'h1);
    check("bad_valid", 64'(cmd_valid), 64'h0);
    check("bad_busy", 64'(busy), 64'h0);
    check("bad_jdo", 64'(jdo), 64'(sr_a2));
    // New bad select in the same cycle as clr_status: set wins
    vs_udr = 1'b1; tick; vs_udr = 1'b0; tick;
    clr_status = 1'b1; tick; clr_status = 1'b0;
    check("bad_set_wins", 64'(err_badsel), 64'h1);
    clr_status = 1'b1; tick; clr_status = 1'b0;
    check("bad_clr", 64'(err_badsel), 64'h0);

    // uir and udr together, target core 2
    sr = sr_c; ir_in = 2'b11;
    vs_udr = 1'b1; vs_uir = 1'b1; tick;
    vs_udr = 1'b0; vs_uir = 1'b0; tick; tick;
    check("both_valid", 64'(cmd_valid), 64'h4);
    check("both_irupd", 64'(ir_update), 64'h1);
    check("both_ir", 64'(cmd_ir), 64'h3);

    // Timeout boundary: 8 PEND cycles without ack
    repeat (7) tick;
    check("to_pre_valid", 64'(cmd_valid), 64'h4);
    tick;
`ifdef DBG_CMD_TIMEOUT_EN
    check("to_valid", 64'(cmd_valid), 64'h0);
    check("to_flag", 64'(err_timeout), 64'h1);
    clr_status = 1'b1; tick; clr_status = 1'b0;
    check("to_clr", 64'(err_timeout), 64'h0);
`else
    check("to_valid", 64'(cmd_valid), 64'h4);
    check("to_flag", 64'(err_timeout), 64'h0);
    cmd_ack = 3'b100; tick; cmd_ack = '0;
`endif

    // Reset mid-PEND clears everything without a clock edge
    sr = sr_a; ir_in = 2'b01;
    udr_strobe;
    sr = sr_c;
    udr_strobe;
    check("prerst_ovr", 64'(err_overrun), 64'h1);
    reset_n = 1'b0;
    #2;
    check("arst_valid", 64'(cmd_valid), 64'h0);
    check("arst_busy", 64'(busy), 64'h0);
    check("arst_jdo", 64'(jdo), 64'h0);
    check("arst_errs", 64'({err_overrun, err_badsel, err_timeout}), 64'h0);
    tick;
    reset_n = 1'b1;
    repeat (4) tick;
    check("post_rst_valid", 64'(cmd_valid), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dbg_cmd_bridge_sysclk.md
Name: dbg_cmd_bridge_sysclk

Overview:
- System-clock half of the multicore debug slave.
- Takes the virtual-JTAG update strobes and the scanned data/IR, synchronises the strobes into clk, and captures each command once.
- Routes the command to one of NUM_CORES CPU debug modules with a per-core valid/ack handshake, replacing the single-core fixed take_action decode.
- Flags overrun and bad-select conditions in sticky status bits.

Parameters:
- SR_W, 38: width of scan register sr and of jdo.
- IR_W, 2: virtual-JTAG IR width.
- NUM_CORES, 2: number of target CPU debug modules (1..16).
- SEL_W, 1: width of the core-select field in sr; must satisfy 2**SEL_W >= NUM_CORES.
- SYNC_STAGES, 2: flops in each strobe synchroniser (2..4).
- TIMEOUT_CYCLES, 1024: ack timeout; used only with DBG_CMD_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; single clock for the whole block.
- reset_n  in  1  asynchronous, active-low reset.
- ir_in  in  IR_W  JTAG IR; quasi-static while vs_udr/vs_uir pulse.
- sr  in  SR_W  JTAG scan register; quasi-static after update.
- vs_udr  in  1  virtual Update-DR strobe, tck domain.
- vs_uir  in  1  virtual Update-IR strobe, tck domain.
- cmd_ack  in  NUM_CORES  per-core command acknowledge.
- clr_status  in  1  one-cycle pulse; clears all sticky flags.
- jdo  out  SR_W  captured sr of the current/last accepted command.
- cmd_ir  out  IR_W  captured ir_in of the current command.
- cmd_action  out  1  captured sr[SR_W-1]: 1 = take_action, 0 = take_no_action.
- cmd_valid  out  NUM_CORES  one-hot; the target core has a pending command.
- ir_update  out  1  one-cycle pulse per synchronised vs_uir rise.
- busy  out  1  a command is pending.
- err_overrun  out  1  sticky: vs_udr arrived while busy.
- err_badsel  out  1  sticky: select field >= NUM_CORES.
- err_timeout  out  1  sticky timeout flag; constant 0 without DBG_CMD_TIMEOUT_EN.

Behaviour:
- Reset (async assert, synchronous release): all synchroniser flops, jdo, cmd_ir, cmd_action, cmd_valid, ir_update, busy and all err_* go to 0; FSM goes to IDLE.
- Synchronisers: vs_udr and vs_uir each pass through SYNC_STAGES flops plus one history flop. A pulse is asserted on a 0->1 transition of the last stage, for exactly 1 cycle. Each input edge gives one pulse, regardless of how long the strobe is held.
- Timing: a strobe high before clock edge E1 makes cmd_valid/ir_update visible after edge E(SYNC_STAGES+1); with the default, that is the 3rd edge.
- sr and ir_in are sampled directly, without synchronisers. The JTAG side holds them stable for at least SYNC_STAGES+2 clk cycles after the strobe.
- Target select: sel = sr[SR_W-2 -: SEL_W].
- FSM state IDLE:
  - udr_pulse with sel < NUM_CORES: capture jdo<=sr, cmd_ir<=ir_in, cmd_action<=sr[SR_W-1]; set cmd_valid[sel]=1, busy=1; go to PEND.
  - udr_pulse with sel >= NUM_CORES: set err_badsel; capture nothing; stay in IDLE.
- FSM state PEND:
  - cmd_valid stays stable until cmd_ack[sel] is high at a clock edge. cmd_valid then drops on the next cycle and the FSM returns to IDLE.
  - Acks on non-target lanes are ignored.
  - udr_pulse while PEND with no ack that cycle: set err_overrun; drop the new command; jdo/cmd_ir unchanged.
  - udr_pulse in the same cycle as a valid ack: the new command is accepted as if in IDLE. cmd_valid moves to the new sel on the next cycle, and may stay asserted on the same lane; busy stays 1.
- ir_update:
  - Pulses independently of the FSM and does not alter jdo.
  - uir and udr pulses in the same cycle are both handled.
- clr_status: clears err_* on the next edge. A set event in the same cycle as clr_status wins, so the flag stays 1.
- Reset mid-PEND: abandons the command; cmd_valid drops immediately on reset assertion.

Optional Feature:
- Macro: DBG_CMD_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to PEND and increments each PEND cycle.
  - When it reaches TIMEOUT_CYCLES-1 without an ack, cmd_valid drops, the FSM goes to IDLE and err_timeout is set. The command is not retried.
  - An ack on the terminal cycle takes precedence, and err_timeout is not set.
- Undefined: no counter is built, PEND waits indefinitely, and err_timeout is tied to 0.

Test Plan:
- Basic route: sr=38'h1_0000_00AB (sel=0, action=0), ir_in=2'b01, vs_udr pulse -> cmd_valid=2'b01 after 3 edges, jdo=38'h1_0000_00AB, cmd_action=0, cmd_ir=01; cmd_ack[0] -> cmd_valid=0, busy=0 next cycle.
- Second core + action: sr[37]=1, sr[36]=1 -> cmd_valid=2'b10, cmd_action=1; cmd_ack[0] held high -> no change; cmd_ack[1] releases.
- Overrun: second vs_udr while PEND and unacked -> err_overrun=1, jdo keeps first value; clr_status -> err_overrun=0.
- Ack/new collision: cmd_ack[0] in the same cycle as the next udr_pulse targeting core 1 -> cmd_valid goes 01->10 with no idle cycle, err_overrun=0.
- Long strobe: vs_udr held high 20 cycles -> exactly one command captured; vs_uir pulse -> ir_update high for exactly 1 cycle.
- NUM_CORES=3, SEL_W=2, sel=3 -> err_badsel=1, cmd_valid=0. With DBG_CMD_TIMEOUT_EN and TIMEOUT_CYCLES=8, no ack -> cmd_valid drops after 8 PEND cycles and err_timeout=1. Reset asserted mid-PEND -> all outputs 0 asynchronously.
